// File: rtl/panda_mem_arbiter.sv
// panda_mem_arbiter: shares one req/gnt/rvalid memory port between instruction fetch
// and the load/store unit, round-robin, with a single outstanding transaction.
module panda_mem_arbiter #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   instr_req_i,
    input  logic [AddrWidth-1:0]   instr_addr_i,
    output logic                   instr_gnt_o,
    output logic                   instr_rvalid_o,
    output logic [DataWidth-1:0]   instr_rdata_o,

    input  logic                   data_req_i,
    input  logic [AddrWidth-1:0]   data_addr_i,
    input  logic [DataWidth/8-1:0] data_we_i,
    input  logic [DataWidth-1:0]   data_wdata_i,
    output logic                   data_gnt_o,
    output logic                   data_rvalid_o,
    output logic [DataWidth-1:0]   data_rdata_o,

    output logic                   mem_req_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth/8-1:0] mem_we_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_WAIT} state_e;
    typedef enum logic {PORT_DATA, PORT_INSTR} port_e;

    state_e state_q, state_d;
    port_e  owner_q, owner_d;
    port_e  rr_q, rr_d;
    port_e  sel;
    logic   sel_valid;
    logic   arb_en;

    // Winner selection; LOCKED holds the registered owner, otherwise arbitrate.
    always_comb begin
        arb_en    = (state_q == ST_IDLE) || ((state_q == ST_WAIT) && mem_rvalid_i);
        sel       = owner_q;
        sel_valid = 1'b0;
        if (state_q == ST_LOCKED) begin
            sel_valid = 1'b1;
        end else if (arb_en) begin
            sel_valid = instr_req_i | data_req_i;
            if (instr_req_i && data_req_i) begin
                sel = rr_q;
            end else if (instr_req_i) begin
                sel = PORT_INSTR;
            end else begin
                sel = PORT_DATA;
            end
        end
        // Keep every handshake output quiet while reset is held.
        sel_valid = sel_valid & rst_ni;
    end

    always_comb begin
        mem_req_o   = sel_valid;
        mem_addr_o  = '0;
        mem_we_o    = '0;
        mem_wdata_o = '0;
        if (sel_valid) begin
            if (sel == PORT_INSTR) begin
                mem_addr_o = instr_addr_i;
            end else begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_wdata_o = data_wdata_i;
            end
        end
        instr_gnt_o    = sel_valid && mem_gnt_i && (sel == PORT_INSTR);
        data_gnt_o     = sel_valid && mem_gnt_i && (sel == PORT_DATA);
        instr_rvalid_o = rst_ni && (state_q == ST_WAIT) && mem_rvalid_i && (owner_q == PORT_INSTR);
        data_rvalid_o  = rst_ni && (state_q == ST_WAIT) && mem_rvalid_i && (owner_q == PORT_DATA);
    end

    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        if (sel_valid) begin
            owner_d = sel;
            if (mem_gnt_i) begin
                state_d = ST_WAIT;
                rr_d    = (sel == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
            end else begin
                state_d = ST_LOCKED;
            end
        end else if ((state_q == ST_WAIT) && mem_rvalid_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= PORT_DATA;
            rr_q    <= PORT_DATA;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// Self-checking bench for panda_mem_arbiter: directed scenarios plus randomized
// traffic, all compared every cycle against a transaction-level reference model.
module tb_panda_mem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int BW      = DW / 8;
    localparam int P_NONE  = -1;
    localparam int P_DATA  = 0;
    localparam int P_INSTR = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_req, instr_gnt, instr_rvalid;
    logic [AW-1:0] instr_addr;
    logic [DW-1:0] instr_rdata;
    logic          data_req, data_gnt, data_rvalid;
    logic [AW-1:0] data_addr;
    logic [BW-1:0] data_we;
    logic [DW-1:0] data_wdata, data_rdata;
    logic          mem_req, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: last granted port, port waiting for a grant, port awaiting a response.
    int m_last  = P_INSTR;
    int m_pend  = P_NONE;
    int m_await = P_NONE;

    always #5 clk = ~clk;

    panda_mem_arbiter #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
        .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_rdata_o(data_rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    function automatic int pick();
        if (!rst_n) return P_NONE;
        if (m_pend != P_NONE) return m_pend;
        if (m_await != P_NONE && !mem_rvalid) return P_NONE;
        if (instr_req && data_req) return (m_last == P_DATA) ? P_INSTR : P_DATA;
        if (data_req) return P_DATA;
        if (instr_req) return P_INSTR;
        return P_NONE;
    endfunction

    function automatic logic [136:0] exp_vec();
        int p;
        logic ig, ir, dg, dr, mr;
        logic [AW-1:0] a;
        logic [BW-1:0] we;
        logic [DW-1:0] wd;
        p  = pick();
        ig = (p == P_INSTR) && mem_gnt;
        dg = (p == P_DATA) && mem_gnt;
        ir = rst_n && (m_await == P_INSTR) && mem_rvalid;
        dr = rst_n && (m_await == P_DATA) && mem_rvalid;
        mr = (p != P_NONE);
        a  = (p == P_INSTR) ? instr_addr : (p == P_DATA) ? data_addr : '0;
        we = (p == P_DATA) ? data_we : '0;
        wd = (p == P_DATA) ? data_wdata : '0;
        return {ig, ir, dg, dr, mr, a, we, wd, mem_rdata, mem_rdata};
    endfunction

    function automatic logic [136:0] dut_vec();
        return {instr_gnt, instr_rvalid, data_gnt, data_rvalid, mem_req,
                mem_addr, mem_we, mem_wdata, instr_rdata, data_rdata};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int p;
        if (!rst_n) begin
            m_last  <= P_INSTR;
            m_pend  <= P_NONE;
            m_await <= P_NONE;
        end else begin
            assert (!((m_pend == P_INSTR && !instr_req) || (m_pend == P_DATA && !data_req)))
                else $error("requester dropped req while its request was locked");
            p = pick();
            if (p != P_NONE) begin
                if (mem_gnt) begin
                    m_await <= p;
                    m_pend  <= P_NONE;
                    m_last  <= p;
                end else begin
                    m_pend  <= p;
                    m_await <= P_NONE;
                end
            end else if (m_await != P_NONE && mem_rvalid) begin
                m_await <= P_NONE;
            end
        end
    end

    task automatic idle_inputs();
        instr_req = 0; instr_addr = '0;
        data_req = 0; data_addr = '0; data_we = '0; data_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        instr_req = 1; data_req = 1; mem_gnt = 1; mem_rvalid = 1;
        data_addr = 32'h1234; data_we = 4'hF;
        #1;
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h exp %h", dut_vec(), exp_vec());
        end
        n_checks++;
        if ({instr_gnt, data_gnt, instr_rvalid, data_rvalid, mem_req, mem_addr, mem_we, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h exp 0",
                     {instr_gnt, data_gnt, instr_rvalid, data_rvalid, mem_req, mem_addr, mem_we, mem_wdata});
        end
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_only();
        idle_inputs();
        instr_req = 1; instr_addr = 32'h0; mem_gnt = 1;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL fetch_grant_model: got %h exp %h", dut_vec(), exp_vec());
        end
        n_checks++;
        if ({instr_gnt, data_gnt, mem_req, mem_addr} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL fetch_grant: got %b%b%b %h exp 1 0 1 0", instr_gnt, data_gnt, mem_req, mem_addr);
        end
        @(posedge clk); #1;
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h00A00093;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL fetch_resp_model: got %h exp %h", dut_vec(), exp_vec());
        end
        n_checks++;
        if ({instr_rvalid, data_rvalid, instr_rdata} !== {1'b1, 1'b0, 32'h00A00093}) begin
            n_fail++; $display("FAIL fetch_resp: got %b %b %h exp 1 0 00a00093", instr_rvalid, data_rvalid, instr_rdata);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        instr_req = 1; instr_addr = 32'h4;
        data_req = 1; data_addr = 32'h10; data_we = 4'hF; data_wdata = 32'h0000000A;
        mem_gnt = 1;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL simul_c0_model: got %h exp %h", dut_vec(), exp_vec());
        end
        n_checks++;
        if ({data_gnt, instr_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h10, 32'hA}) begin
            n_fail++; $display("FAIL simul_data_first: got %b %b %h %h %h", data_gnt, instr_gnt, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        data_req = 0; data_we = '0; mem_rvalid = 1; mem_rdata = 32'h5;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL simul_c1_model: got %h exp %h", dut_vec(), exp_vec());
        end
        n_checks++;
        if ({data_rvalid, instr_gnt, mem_addr, mem_we} !== {1'b1, 1'b1, 32'h4, 4'h0}) begin
            n_fail++; $display("FAIL simul_fetch_next: got %b %b %h %h exp 1 1 4 0", data_rvalid, instr_gnt, mem_addr, mem_we);
        end
        @(posedge clk); #1;
        instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = $urandom;
        @(negedge clk);
        n_checks++;
        if ({instr_rvalid, data_rvalid} !== 2'b10 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL simul_fetch_resp: got %h exp %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        instr_req = 1; instr_addr = $urandom;
        data_req = 1; data_addr = $urandom; data_we = 4'($urandom); data_wdata = $urandom;
        mem_gnt = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL contention_model_%0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            n_checks++;
            if ({data_gnt, instr_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL contention_order_%0d: got data/instr gnt %b%b", i, data_gnt, instr_gnt);
            end
            @(posedge clk); #1;
            mem_rvalid = 1; mem_rdata = $urandom;
            if (i % 2 == 0) begin
                data_addr = $urandom; data_we = 4'($urandom); data_wdata = $urandom;
            end else begin
                instr_addr = $urandom;
            end
        end
        instr_req = 0; data_req = 0; mem_gnt = 0;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL contention_drain: got %h exp %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        instr_req = 1; instr_addr = 32'h8;
        for (int c = 0; c < 4; c++) begin
            data_req = (c >= 1); data_addr = 32'h20;
            mem_gnt = (c == 3);
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stall_model_%0d: got %h exp %h", c, dut_vec(), exp_vec());
            end
            n_checks++;
            if ({mem_req, mem_addr, data_gnt, instr_gnt} !== {1'b1, 32'h8, 1'b0, (c == 3)}) begin
                n_fail++; $display("FAIL stall_locked_%0d: got %b %h %b %b", c, mem_req, mem_addr, data_gnt, instr_gnt);
            end
            @(posedge clk); #1;
        end
        instr_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = $urandom;
        @(negedge clk);
        n_checks++;
        if ({instr_rvalid, data_gnt, mem_addr} !== {1'b1, 1'b1, 32'h20} || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL stall_handover: got %h exp %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        data_req = 0; mem_gnt = 0; mem_rvalid = 1;
        @(negedge clk);
        n_checks++;
        if (data_rvalid !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL stall_data_resp: got %h exp %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_halfword();
        int rv_cnt;
        idle_inputs();
        data_req = 1; data_addr = 32'h14; data_we = 4'h3; data_wdata = $urandom; mem_gnt = 1;
        @(negedge clk);
        n_checks++;
        if ({data_gnt, mem_we, mem_addr} !== {1'b1, 4'h3, 32'h14} || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL half_grant: got %h exp %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        idle_inputs();
        rv_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            mem_rvalid = (c == 4); mem_rdata = $urandom;
            @(negedge clk);
            rv_cnt += int'(data_rvalid);
            n_checks++;
            if (dut_vec() !== exp_vec() || (c < 4 && mem_req !== 1'b0)) begin
                n_fail++; $display("FAIL half_wait_%0d: got %h exp %h", c, dut_vec(), exp_vec());
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (rv_cnt !== 1) begin
            n_fail++; $display("FAIL half_rvalid_count: got %0d exp 1", rv_cnt);
        end
        mem_rvalid = 1;
        @(negedge clk);
        n_checks++;
        if ({instr_rvalid, data_rvalid} !== 2'b00 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL spurious_idle: got %b%b exp 00", instr_rvalid, data_rvalid);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        idle_inputs();
        instr_req = 1; instr_addr = 32'h40; mem_gnt = 1;
        @(negedge clk);
        n_checks++;
        if (instr_gnt !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL rstwait_grant: got %h exp %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        idle_inputs();
        mem_rvalid = 1;
        rst_n = 0;
        #1;
        n_checks++;
        if ({instr_gnt, data_gnt, instr_rvalid, data_rvalid, mem_req, mem_addr, mem_we, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL rstwait_outputs: got %h exp 0", dut_vec());
        end
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        n_checks++;
        if ({instr_rvalid, data_rvalid} !== 2'b00 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL rstwait_stale_rvalid: got %h exp %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        idle_inputs();
        instr_req = 1; instr_addr = 32'h0; mem_gnt = 1;
        @(negedge clk);
        n_checks++;
        if ({instr_gnt, mem_addr} !== {1'b1, 32'h0} || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL rstwait_fresh_grant: got %h exp %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h00A00093;
        @(negedge clk);
        n_checks++;
        if ({instr_rvalid, instr_rdata} !== {1'b1, 32'h00A00093} || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL rstwait_fresh_resp: got %h exp %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_random();
        logic i_done, d_done;
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            mem_gnt    = ($urandom_range(0, 3) != 0);
            mem_rvalid = ($urandom_range(0, 1) != 0);
            mem_rdata  = $urandom;
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d: got %h exp %h", c, dut_vec(), exp_vec());
            end
            i_done = (pick() == P_INSTR) && mem_gnt;
            d_done = (pick() == P_DATA) && mem_gnt;
            @(posedge clk); #1;
            if (!instr_req || i_done) begin
                instr_req  = ($urandom_range(0, 2) != 0);
                instr_addr = $urandom;
            end
            if (!data_req || d_done) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_addr  = $urandom;
                data_we    = 4'($urandom);
                data_wdata = $urandom;
            end
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_contention();
        test_stall();
        test_halfword();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
